// File: rtl/turn_manager_if.sv
`default_nettype none
// ============================================================================
//  Module      : turn_manager_if
//  Description : Bus between the turn sequencer and its surroundings: the
//                keyboard, frame strobe and player status coming in, plus the
//                per-player keycodes and game status going out.
//  Revision    : 1.0 - initial release
// ============================================================================
interface turn_manager_if;
  logic       frame_clk;
  logic [7:0] keycode_in;
  logic [9:0] hp0;
  logic [9:0] hp1;
  logic       boomed0;
  logic       boomed1;
  logic [7:0] keycode0;
  logic [7:0] keycode1;
  logic       player_reset;
  logic       active_player;
  logic [9:0] turn_timer;
  logic [2:0] state;
  logic [1:0] winner;
  logic       game_over;

  // Game-side view: drives the strobe, keys and player status.
  modport master (
    output frame_clk, keycode_in, hp0, hp1, boomed0, boomed1,
    input  keycode0, keycode1, player_reset, active_player,
           turn_timer, state, winner, game_over
  );

  // Sequencer view.
  modport slave (
    input  frame_clk, keycode_in, hp0, hp1, boomed0, boomed1,
    output keycode0, keycode1, player_reset, active_player,
           turn_timer, state, winner, game_over
  );
endinterface
`default_nettype wire

// File: rtl/turn_manager.sv
`default_nettype none
// ============================================================================
//  Module      : turn_manager
//  Description : Two-player artillery turn sequencer. Routes the keycode to
//                the player holding the turn, follows the bomb through flight
//                and detonation, then hands over the turn or declares a winner.
//  Revision    : 1.0 - initial release
// ============================================================================
module turn_manager #(
  parameter logic [7:0] START_KEY     = 8'h28,
  parameter logic [7:0] SHOOT_KEY0    = 8'h16,
  parameter logic [7:0] SHOOT_KEY1    = 8'h51,
  parameter logic [9:0] TURN_FRAMES   = 10'd600,
  parameter logic [9:0] FLIGHT_FRAMES = 10'd240,
  parameter logic [9:0] SETTLE_FRAMES = 10'd48
) (
  input  logic              clk,
  input  logic              reset,   // asynchronous, active-low
  turn_manager_if.slave     bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    AIM    = 3'd1,
    FLIGHT = 3'd2,
    SETTLE = 3'd3,
    CHECK  = 3'd4,
    OVER   = 3'd5
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] keycode0_q, keycode0_d;
  logic [7:0] keycode1_q, keycode1_d;
  logic       player_reset_q, player_reset_d;
  logic       active_player_q, active_player_d;
  logic [9:0] turn_timer_q, turn_timer_d;
  logic [1:0] winner_q, winner_d;
  logic       game_over_q, game_over_d;
  logic       frame_clk_q;
  logic [7:0] prev_key_q;
  logic       prev_boom0_q;
  logic       prev_boom1_q;

  logic       tick;
  logic       dead0;
  logic       dead1;
  logic [7:0] shoot_key;
  logic       shoot_release;
  logic       boom_edge;
  logic       timer_zero;

  // Event decode: frame tick, health, shoot release and detonation edge.
  always_comb begin
    tick          = bus.frame_clk & ~frame_clk_q;
    // A wrapped (negative) health value counts as dead.
    dead0         = (bus.hp0 == 10'd0) | bus.hp0[9];
    dead1         = (bus.hp1 == 10'd0) | bus.hp1[9];
    shoot_key     = active_player_q ? SHOOT_KEY1 : SHOOT_KEY0;
    shoot_release = (prev_key_q == shoot_key) & (bus.keycode_in != shoot_key);
    boom_edge     = active_player_q ? (bus.boomed1 & ~prev_boom1_q)
                                    : (bus.boomed0 & ~prev_boom0_q);
    timer_zero    = (turn_timer_q == 10'd0);
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d         = state_q;
    keycode0_d      = 8'h00;
    keycode1_d      = 8'h00;
    active_player_d = active_player_q;
    turn_timer_d    = turn_timer_q;
    winner_d        = winner_q;

    // Keys reach a player only while that player is aiming.
    if (state_q == AIM) begin
      if (active_player_q) keycode1_d = bus.keycode_in;
      else                 keycode0_d = bus.keycode_in;
    end

    case (state_q)
      IDLE: begin
        if (bus.keycode_in == START_KEY) begin
          state_d         = AIM;
          active_player_d = 1'b0;
          turn_timer_d    = TURN_FRAMES;
        end
      end
      AIM: begin
        if (dead0 | dead1) begin
          state_d = CHECK;
        end else if (shoot_release) begin
          // Release beats a same-cycle expiry tick.
          state_d      = FLIGHT;
          turn_timer_d = FLIGHT_FRAMES;
        end else if (tick) begin
          if (timer_zero) begin
            state_d      = SETTLE;
            turn_timer_d = SETTLE_FRAMES;
          end else begin
            turn_timer_d = turn_timer_q - 10'd1;
          end
        end
      end
      FLIGHT: begin
        // Detonation and timeout land in the same place.
        if (boom_edge | (tick & timer_zero)) begin
          state_d      = SETTLE;
          turn_timer_d = SETTLE_FRAMES;
        end else if (tick) begin
          turn_timer_d = turn_timer_q - 10'd1;
        end
      end
      SETTLE: begin
        if (tick) begin
          if (timer_zero) state_d      = CHECK;
          else            turn_timer_d = turn_timer_q - 10'd1;
        end
      end
      CHECK: begin
        if (dead0 & dead1) begin
          winner_d = 2'd3;
          state_d  = OVER;
        end else if (dead0) begin
          winner_d = 2'd2;
          state_d  = OVER;
        end else if (dead1) begin
          winner_d = 2'd1;
          state_d  = OVER;
        end else begin
          active_player_d = ~active_player_q;
          turn_timer_d    = TURN_FRAMES;
          state_d         = AIM;
        end
      end
      OVER: begin
        if (bus.keycode_in == START_KEY) begin
          state_d  = IDLE;
          winner_d = 2'd0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Status flags reflect the state being entered on this edge.
    player_reset_d = (state_d == IDLE);
    game_over_d    = (state_d == OVER);
  end

  // State and output registers; reset aborts any turn back to IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= IDLE;
      keycode0_q      <= 8'h00;
      keycode1_q      <= 8'h00;
      player_reset_q  <= 1'b1;
      active_player_q <= 1'b0;
      turn_timer_q    <= 10'd0;
      winner_q        <= 2'd0;
      game_over_q     <= 1'b0;
      frame_clk_q     <= 1'b0;
      prev_key_q      <= 8'h00;
      prev_boom0_q    <= 1'b0;
      prev_boom1_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      keycode0_q      <= keycode0_d;
      keycode1_q      <= keycode1_d;
      player_reset_q  <= player_reset_d;
      active_player_q <= active_player_d;
      turn_timer_q    <= turn_timer_d;
      winner_q        <= winner_d;
      game_over_q     <= game_over_d;
      frame_clk_q     <= bus.frame_clk;
      prev_key_q      <= bus.keycode_in;
      prev_boom0_q    <= bus.boomed0;
      prev_boom1_q    <= bus.boomed1;
    end
  end

  assign bus.keycode0      = keycode0_q;
  assign bus.keycode1      = keycode1_q;
  assign bus.player_reset  = player_reset_q;
  assign bus.active_player = active_player_q;
  assign bus.turn_timer    = turn_timer_q;
  assign bus.state         = state_q;
  assign bus.winner        = winner_q;
  assign bus.game_over     = game_over_q;

endmodule
`default_nettype wire

// File: tb/tb_turn_manager.sv
`default_nettype none
// ============================================================================
//  Module      : tb_turn_manager
//  Description : Self-checking bench for turn_manager: directed vector table,
//                hand-written turn sequences and random play against a
//                behavioural game model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_turn_manager;
  localparam int C_START  = 8'h28;
  localparam int C_SK0    = 8'h16;
  localparam int C_SK1    = 8'h51;
  localparam int C_TURN   = 600;
  localparam int C_FLIGHT = 240;
  localparam int C_SETTLE = 48;

  localparam int P_IDLE = 0, P_AIM = 1, P_FLIGHT = 2, P_SETTLE = 3, P_CHECK = 4, P_OVER = 5;

  logic clk;
  logic reset;
  turn_manager_if bus();

  turn_manager dut (.clk(clk), .reset(reset), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_fail;

  // ---------------- behavioural game model ----------------
  int m_phase, m_kc0, m_kc1, m_pr, m_player, m_left, m_win, m_go;
  int m_last_fc, m_last_key, m_last_b0, m_last_b1;

  function automatic bit is_dead(input int hp);
    return (hp == 0) || (hp >= 512);
  endfunction

  task automatic model_reset();
    m_phase = P_IDLE; m_kc0 = 0; m_kc1 = 0; m_pr = 1; m_player = 0;
    m_left = 0; m_win = 0; m_go = 0;
    m_last_fc = 0; m_last_key = 0; m_last_b0 = 0; m_last_b1 = 0;
  endtask

  task automatic model_edge(input int k, input int fc, input int h0, input int h1,
                            input int b0, input int b1);
    bit tick, released, boomed;
    int my_shoot, next_phase;
    tick     = (fc == 1) && (m_last_fc == 0);
    my_shoot = (m_player == 1) ? C_SK1 : C_SK0;
    released = (m_last_key == my_shoot) && (k != my_shoot);
    boomed   = (m_player == 1) ? (b1 == 1 && m_last_b1 == 0) : (b0 == 1 && m_last_b0 == 0);
    // key delivery depends on who is aiming right now
    m_kc0 = (m_phase == P_AIM && m_player == 0) ? k : 0;
    m_kc1 = (m_phase == P_AIM && m_player == 1) ? k : 0;
    next_phase = m_phase;
    if (m_phase == P_IDLE) begin
      if (k == C_START) begin next_phase = P_AIM; m_player = 0; m_left = C_TURN; end
    end else if (m_phase == P_AIM) begin
      if (is_dead(h0) || is_dead(h1)) next_phase = P_CHECK;
      else if (released) begin next_phase = P_FLIGHT; m_left = C_FLIGHT; end
      else if (tick && m_left == 0) begin next_phase = P_SETTLE; m_left = C_SETTLE; end
      else if (tick) m_left = m_left - 1;
    end else if (m_phase == P_FLIGHT) begin
      if (boomed || (tick && m_left == 0)) begin next_phase = P_SETTLE; m_left = C_SETTLE; end
      else if (tick) m_left = m_left - 1;
    end else if (m_phase == P_SETTLE) begin
      if (tick && m_left == 0) next_phase = P_CHECK;
      else if (tick) m_left = m_left - 1;
    end else if (m_phase == P_CHECK) begin
      m_win = (is_dead(h1) ? 1 : 0) + (is_dead(h0) ? 2 : 0);
      if (m_win != 0) next_phase = P_OVER;
      else begin next_phase = P_AIM; m_player = 1 - m_player; m_left = C_TURN; end
    end else if (m_phase == P_OVER) begin
      if (k == C_START) begin next_phase = P_IDLE; m_win = 0; end
    end
    m_phase    = next_phase;
    m_pr       = (m_phase == P_IDLE) ? 1 : 0;
    m_go       = (m_phase == P_OVER) ? 1 : 0;
    m_last_fc  = fc; m_last_key = k; m_last_b0 = b0; m_last_b1 = b1;
  endtask

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic check_model();
    check("state",  32'(bus.state),         32'(m_phase));
    check("timer",  32'(bus.turn_timer),    32'(m_left));
    check("kc0",    32'(bus.keycode0),      32'(m_kc0));
    check("kc1",    32'(bus.keycode1),      32'(m_kc1));
    check("active", 32'(bus.active_player), 32'(m_player));
    check("preset", 32'(bus.player_reset),  32'(m_pr));
    check("winner", 32'(bus.winner),        32'(m_win));
    check("gover",  32'(bus.game_over),     32'(m_go));
  endtask

  // One clock: sample inputs, clock, update model, compare.
  task automatic step();
    int k, fc, h0, h1, b0, b1, rs;
    k = bus.keycode_in; fc = bus.frame_clk; h0 = bus.hp0; h1 = bus.hp1;
    b0 = bus.boomed0; b1 = bus.boomed1; rs = reset;
    @(posedge clk);
    if (rs == 0) model_reset();
    else model_edge(k, fc, h0, h1, b0, b1);
    #1;
    check_model();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      bus.frame_clk = 1'b1; step();
      bus.frame_clk = 1'b0; step();
    end
  endtask

  task automatic key(input int k);
    bus.keycode_in = 8'(k); step();
  endtask

  typedef struct {
    logic [7:0] k;
    logic       fc;
    logic       b0;
    logic [2:0] e_state;
    logic [9:0] e_timer;
    logic [7:0] e_kc0;
    logic [7:0] e_kc1;
  } vec_t;

  vec_t vecs[10];

  initial begin
    n_cmp = 0; n_fail = 0;
    vecs[0] = '{8'h04, 1'b0, 1'b0, 3'd1, 10'd600, 8'h04, 8'h00};
    vecs[1] = '{8'h16, 1'b0, 1'b0, 3'd1, 10'd600, 8'h16, 8'h00};
    vecs[2] = '{8'h16, 1'b0, 1'b0, 3'd1, 10'd600, 8'h16, 8'h00};
    vecs[3] = '{8'h16, 1'b0, 1'b0, 3'd1, 10'd600, 8'h16, 8'h00};
    vecs[4] = '{8'h00, 1'b0, 1'b0, 3'd2, 10'd240, 8'h00, 8'h00};
    vecs[5] = '{8'h00, 1'b1, 1'b0, 3'd2, 10'd239, 8'h00, 8'h00};
    vecs[6] = '{8'h00, 1'b1, 1'b0, 3'd2, 10'd239, 8'h00, 8'h00};
    vecs[7] = '{8'h00, 1'b0, 1'b0, 3'd2, 10'd239, 8'h00, 8'h00};
    vecs[8] = '{8'h00, 1'b0, 1'b1, 3'd3, 10'd48,  8'h00, 8'h00};
    vecs[9] = '{8'h00, 1'b0, 1'b0, 3'd3, 10'd48,  8'h00, 8'h00};

    bus.frame_clk = 0; bus.keycode_in = 0; bus.hp0 = 10'd100; bus.hp1 = 10'd100;
    bus.boomed0 = 0; bus.boomed1 = 0;
    reset = 1'b0;
    model_reset();
    #2;
    step(); step();
    check("rst_state", 32'(bus.state), 0);
    check("rst_preset", 32'(bus.player_reset), 1);
    check("rst_timer", 32'(bus.turn_timer), 0);
    reset = 1'b1;

    // start
    key(C_START);
    check("start_state", 32'(bus.state), 1);
    check("start_timer", 32'(bus.turn_timer), 600);
    check("start_preset", 32'(bus.player_reset), 0);
    check("start_active", 32'(bus.active_player), 0);

    // routing, shoot and detonation table
    for (int i = 0; i < 10; i++) begin
      bus.keycode_in = vecs[i].k; bus.frame_clk = vecs[i].fc; bus.boomed0 = vecs[i].b0;
      step();
      check($sformatf("vec%0d_state", i), 32'(bus.state), 32'(vecs[i].e_state));
      check($sformatf("vec%0d_timer", i), 32'(bus.turn_timer), 32'(vecs[i].e_timer));
      check($sformatf("vec%0d_kc0", i), 32'(bus.keycode0), 32'(vecs[i].e_kc0));
      check($sformatf("vec%0d_kc1", i), 32'(bus.keycode1), 32'(vecs[i].e_kc1));
    end

    // settle countdown then handover
    ticks(48);
    check("settle_zero", 32'(bus.turn_timer), 0);
    check("settle_state", 32'(bus.state), 3);
    bus.frame_clk = 1'b1; step();
    check("check_state", 32'(bus.state), 4);
    bus.frame_clk = 1'b0; step();
    check("hand_state", 32'(bus.state), 1);
    check("hand_active", 32'(bus.active_player), 1);
    check("hand_timer", 32'(bus.turn_timer), 600);

    // player 1 routing; player 0's shoot key does not fire for player 1
    key(8'h04);
    check("p1_kc1", 32'(bus.keycode1), 8'h04);
    check("p1_kc0", 32'(bus.keycode0), 0);
    key(C_SK0); key(0);
    check("p1_noshot", 32'(bus.state), 1);

    // forfeit after TURN+1 ticks
    ticks(600);
    check("forfeit_t0", 32'(bus.turn_timer), 0);
    check("forfeit_aim", 32'(bus.state), 1);
    ticks(1);
    check("forfeit_state", 32'(bus.state), 3);
    check("forfeit_timer", 32'(bus.turn_timer), 48);
    ticks(49);
    check("forfeit_next", 32'(bus.state), 1);
    check("forfeit_active", 32'(bus.active_player), 0);

    // shoot release and expiry tick together: shoot wins
    ticks(600);
    key(C_SK0);
    bus.keycode_in = 0; bus.frame_clk = 1'b1; step();
    check("race_state", 32'(bus.state), 2);
    check("race_timer", 32'(bus.turn_timer), 240);
    bus.frame_clk = 1'b0; step();

    // detonation and flight timeout together
    ticks(240);
    check("flt_zero", 32'(bus.turn_timer), 0);
    bus.boomed0 = 1'b1; bus.frame_clk = 1'b1; step();
    check("boomto_state", 32'(bus.state), 3);
    check("boomto_timer", 32'(bus.turn_timer), 48);
    bus.boomed0 = 1'b0; bus.frame_clk = 1'b0; step();

    // player 0 wins
    bus.hp1 = 10'd0;
    ticks(49);
    check("win1_state", 32'(bus.state), 5);
    check("win1_winner", 32'(bus.winner), 1);
    check("win1_go", 32'(bus.game_over), 1);
    key(C_START);
    check("restart_state", 32'(bus.state), 0);
    check("restart_winner", 32'(bus.winner), 0);
    check("restart_preset", 32'(bus.player_reset), 1);

    // draw
    key(C_START);
    bus.hp0 = 10'd0; bus.hp1 = 10'd0; key(0); step();
    check("draw_winner", 32'(bus.winner), 3);

    // negative health counts as dead
    key(C_START);
    bus.hp0 = 10'h3F6; bus.hp1 = 10'd100;
    key(C_START); key(0); step();
    check("neg_winner", 32'(bus.winner), 2);
    check("neg_state", 32'(bus.state), 5);

    // asynchronous reset mid-AIM and mid-FLIGHT
    bus.hp0 = 10'd100;
    key(C_START); key(C_START); key(8'h04);
    check("pre_rst_kc0", 32'(bus.keycode0), 8'h04);
    #3 reset = 1'b0; #1;
    model_reset();
    check("arst_aim_state", 32'(bus.state), 0);
    check("arst_aim_kc0", 32'(bus.keycode0), 0);
    step(); reset = 1'b1;
    key(C_START); key(C_SK0); key(0);
    check("pre_rst_flight", 32'(bus.state), 2);
    #3 reset = 1'b0; #1;
    model_reset();
    check("arst_flt_state", 32'(bus.state), 0);
    check("arst_flt_kc0", 32'(bus.keycode0), 0);
    check("arst_flt_kc1", 32'(bus.keycode1), 0);
    step(); reset = 1'b1;

    // random play against the model
    for (int i = 0; i < 16000; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 40)      bus.keycode_in = 8'h00;
      else if (r < 55) bus.keycode_in = 8'h04;
      else if (r < 75) bus.keycode_in = 8'(C_SK0);
      else if (r < 97) bus.keycode_in = 8'(C_SK1);
      else             bus.keycode_in = 8'(C_START);
      bus.frame_clk = 1'($urandom_range(0, 1));
      bus.boomed0   = ($urandom_range(0, 49) == 0);
      bus.boomed1   = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 399) == 0) begin
        r = $urandom_range(0, 5);
        bus.hp0 = (r == 0) ? 10'd0 : (r == 1) ? 10'h3F0 : 10'($urandom_range(1, 511));
        r = $urandom_range(0, 5);
        bus.hp1 = (r == 0) ? 10'd0 : (r == 1) ? 10'h200 : 10'($urandom_range(1, 511));
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/turn_manager.md
# turn_manager

Turn sequencer for the two-player artillery game. It sits between the keyboard interface and the two player blocks. It routes the shared keycode to whichever player holds the turn and watches that player's bomb through flight and detonation. After each turn it reads both health values, then either hands the turn over or declares a winner.

## Interface
Parameters:
- START_KEY, 8'h28, keycode that starts or restarts a game (Enter)
- SHOOT_KEY0, 8'h16, player 0 shoot keycode
- SHOOT_KEY1, 8'h51, player 1 shoot keycode
- TURN_FRAMES, 10'd600, aim time per turn, in frames
- FLIGHT_FRAMES, 10'd240, maximum bomb flight time, in frames
- SETTLE_FRAMES, 10'd48, post-impact wait so damage and recovery can land

Ports:
- clk  in  1  system clock; the only clock in this block
- reset  in  1  asynchronous, active-low (0 = reset)
- frame_clk  in  1  vertical-sync strobe; sampled as data, rising edge gives one-cycle `tick`
- keycode_in  in  8  keyboard keycode, 0 when no key is pressed
- hp0, hp1  in  10  player health
- boomed0, boomed1  in  1  player bomb detonation flags
- keycode0, keycode1  out  8  registered keycode delivered to each player
- player_reset  out  1  active-high hold for both player blocks
- active_player  out  1  player that holds the turn
- turn_timer  out  10  frames left in the current AIM, FLIGHT or SETTLE phase
- state  out  3  IDLE=0, AIM=1, FLIGHT=2, SETTLE=3, CHECK=4, OVER=5
- winner  out  2  0 none, 1 player 0, 2 player 1, 3 draw
- game_over  out  1  high in OVER

## Operation
- `tick` = frame_clk & ~frame_clk_q, where frame_clk_q is a flop. All countdowns advance on `tick` only.
- IDLE: player_reset=1, both keycodes 0. When keycode_in==START_KEY: active_player←0, turn_timer←TURN_FRAMES, go to AIM.
- AIM: the active player's keycode←keycode_in and the other player's keycode←0. Exits, in priority order:
  - hp0==0 or hp1==0 → CHECK.
  - Shoot release (registered previous keycode_in == active SHOOT_KEY and current ≠ it) → FLIGHT, timer←FLIGHT_FRAMES. On the release cycle the active keycode is already the non-shoot value, so the player block still sees the release.
  - On `tick` with timer==0 → SETTLE, timer←SETTLE_FRAMES. The turn is forfeited.
  - Otherwise timer decrements on `tick`.
- FLIGHT: both keycodes 0.
  - Rising edge of the active player's boomed (registered compare) → SETTLE, timer←SETTLE_FRAMES.
  - `tick` with timer==0 → SETTLE (dud or off-screen bomb).
- SETTLE: both keycodes 0. Timer decrements on `tick`; `tick` with timer==0 → CHECK.
- CHECK (one cycle):
  - hp0==0 and hp1==0 → winner=3, OVER.
  - hp0==0 → winner=2, OVER.
  - hp1==0 → winner=1, OVER.
  - else active_player toggles, timer←TURN_FRAMES, AIM.
- Health is zero when hp==0 or hp[9]==1 (negative wrap is treated as dead).
- OVER: both keycodes 0 and game_over=1. START_KEY → IDLE; winner clears on entry to IDLE.
- If keycode_in==START_KEY in any state other than IDLE or OVER, it is forwarded or ignored like any other key.
- Decrementing stops at 0; the timer never wraps.

## Timing
- Reset values: state=IDLE, keycode0=keycode1=0, player_reset=1, active_player=0, turn_timer=0, winner=0, game_over=0, frame_clk_q=0, previous-key and previous-boomed flops 0.
- Reset is asynchronous assert and synchronous deassert behaviour at the next clk; an assertion mid-turn aborts everything to IDLE.
- Every output is a flop. keycodeN follows keycode_in with 1 clk latency.
- A state change takes effect on the clk edge after the triggering condition. Outputs for the new state appear on that same edge.
- Simultaneous events:
  - Shoot release and timer-expiry `tick` in the same cycle: shoot wins.
  - boomed edge and FLIGHT timeout `tick` in the same cycle: both go to SETTLE, with the same result.
- The turn lasts TURN_FRAMES+1 ticks from entry to forfeit, because 0 is also counted.
- player_reset drops on the clk edge that enters AIM from IDLE.

## Test plan
- Reset and start: hold reset=0 → state=0, player_reset=1. Release, drive keycode_in=8'h28 → state=1, active_player=0, turn_timer=600, player_reset=0 on the next edge.
- Key routing: in AIM with player 0 active, drive keycode_in=8'h04 → keycode0=8'h04 and keycode1=0 after 1 clk.
- Full turn cycle (player 0 active):
  - Drive 8'h16 for 3 clks, then 0 → FLIGHT with timer=240.
  - Pulse boomed0 → SETTLE with timer=48.
  - After 49 ticks → CHECK, then AIM with active_player=1 and timer=600.
- Forfeit: in AIM with no shot, supply 601 ticks → SETTLE, then AIM for the other player.
- Win and draw:
  - hp1=0 at CHECK → winner=1, game_over=1, state=5; START_KEY → IDLE with winner=0.
  - hp0=hp1=0 → winner=3.
  - hp0=10'h3F6 (negative) → treated as dead, winner=2.
- Reset mid-FLIGHT: assert reset=0 → state=0 and all keycodes 0 immediately, without waiting for clk.
